// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//
// Free-running single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// After reset it waits GAP clocks with cs high, loads data_in, runs eight
// sck periods while shifting data_in out on MOSI and MISO into a receive
// register, then publishes the received byte on data_out with a one-clock
// done pulse. The sequence then repeats forever.
//
// Parameters
//   SCK_HALF : sck half-period in clk cycles (>= 1)
//   GAP      : clk cycles cs stays high between transfers (>= 1)
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous reset, ACTIVE HIGH (name kept for compatibility)
//   MISO     in   serial data from the slave, sampled on sck rising edges
//   data_in  in   byte to transmit, captured in the LOAD cycle only
//   MOSI     out  serial data to the slave, MSB first
//   data_out out  last completely received byte, updated with done
//   sck      out  SPI clock, idles low
//   cs       out  active-low slave select
//   done     out  one-clk pulse marking a new data_out value
// -----------------------------------------------------------------------------
module spi_master #(
   parameter int SCK_HALF = 2,
   parameter int GAP      = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       MISO,
   input  logic [7:0] data_in,
   output logic       MOSI,
   output logic [7:0] data_out,
   output logic       sck,
   output logic       cs,
   output logic       done
);

   // Counter widths never drop below one bit so SCK_HALF=1 / GAP=1 still
   // produce legal vectors; the terminal count is then simply zero.
   localparam int PH_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
   localparam int GP_W = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic [PH_W-1:0] PH_LAST = PH_W'(SCK_HALF - 1);
   localparam logic [GP_W-1:0] GP_LAST = GP_W'(GAP - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      XFER = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state_q,    state_d;
   logic [PH_W-1:0] phase_q,    phase_d;
   logic [2:0]      bit_q,      bit_d;
   logic [GP_W-1:0] gap_q,      gap_d;
   logic [7:0]      tx_q,       tx_d;
   logic [7:0]      rx_q,       rx_d;
   logic [7:0]      data_out_q, data_out_d;
   logic            mosi_q,     mosi_d;
   logic            sck_q,      sck_d;
   logic            cs_q,       cs_d;
   logic            done_q,     done_d;

   logic            half_end;

   // A half sck period ends when the phase counter reaches its last value.
   assign half_end = (phase_q == PH_LAST);

   // --------------------------------------------------------------------------
   // Next-state and next-output logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      bit_d      = bit_q;
      gap_d      = gap_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      data_out_d = data_out_q;
      mosi_d     = mosi_q;
      sck_d      = sck_q;
      cs_d       = cs_q;
      done_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            cs_d   = 1'b1;
            sck_d  = 1'b0;
            mosi_d = 1'b0;
            if (gap_q == GP_LAST) begin
               gap_d   = '0;
               state_d = LOAD;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end

         LOAD: begin
            // data_in is looked at only here, so changes elsewhere cannot
            // disturb a transfer in flight.
            tx_d    = data_in;
            mosi_d  = data_in[7];
            cs_d    = 1'b0;
            bit_d   = '0;
            phase_d = '0;
            state_d = XFER;
         end

         XFER: begin
            if (half_end) begin
               phase_d = '0;
               if (!sck_q) begin
                  // End of low phase: rising sck edge and MISO capture share
                  // this clk edge, so MISO has had a full half period to settle.
                  sck_d = 1'b1;
                  rx_d  = {rx_q[6:0], MISO};
               end else begin
                  // End of high phase: falling sck edge, MOSI advances here.
                  sck_d = 1'b0;
                  if (bit_q == 3'd7) begin
                     state_d = DONE;
                  end else begin
                     bit_d  = bit_q + 1'b1;
                     tx_d   = {tx_q[6:0], 1'b0};
                     mosi_d = tx_q[6];
                  end
               end
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end

         DONE: begin
            // Only a completed byte reaches data_out; cs rises together with done.
            data_out_d = rx_q;
            done_d     = 1'b1;
            cs_d       = 1'b1;
            mosi_d     = 1'b0;
            gap_d      = '0;
            state_d    = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Control state and registered outputs (reset applies here)
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q    <= IDLE;
         phase_q    <= '0;
         bit_q      <= '0;
         gap_q      <= '0;
         data_out_q <= 8'h00;
         mosi_q     <= 1'b0;
         sck_q      <= 1'b0;
         cs_q       <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         bit_q      <= bit_d;
         gap_q      <= gap_d;
         data_out_q <= data_out_d;
         mosi_q     <= mosi_d;
         sck_q      <= sck_d;
         cs_q       <= cs_d;
         done_q     <= done_d;
      end
   end

   // --------------------------------------------------------------------------
   // Shift registers: always reloaded or fully refilled before use, so they
   // carry no reset.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      tx_q <= tx_d;
      rx_q <= rx_d;
   end

   assign MOSI     = mosi_q;
   assign data_out = data_out_q;
   assign sck      = sck_q;
   assign cs       = cs_q;
   assign done     = done_q;

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//
// Three spi_master instances share one clock:
//   0 : SCK_HALF=2, GAP=2 (defaults) - directed sequence (reset, loopback,
//       patterns, data_in changes, reset mid-transfer)
//   1 : SCK_HALF=1, GAP=1 - free-running with random data
//   2 : SCK_HALF=4, GAP=1 - free-running with random data
// Each instance has a slave model and a transaction monitor that rebuilds
// every transfer from the pins and compares it with the bytes the slave sent
// and the data_in value present when cs fell.
// -----------------------------------------------------------------------------
module tb_spi_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0   = 1'b1;
   logic       rst_sw = 1'b1;
   logic       noise  = 1'b0;
   logic [7:0] din0   = 8'h00;
   logic [7:0] din1   = 8'h00;
   logic [7:0] din2   = 8'h00;

   logic [2:0] mosi_w, sck_w, cs_w, done_w;
   logic [7:0] dout_w [3];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Bytes the slave of instance 0 returns on its first seven transfers.
   function automatic logic [7:0] pat(input int n);
      case (n)
         0:       pat = 8'h5A;
         1:       pat = 8'hFF;
         2:       pat = 8'h00;
         3:       pat = 8'h81;
         4:       pat = 8'h11;
         5:       pat = 8'h22;
         6:       pat = 8'h33;
         default: pat = 8'h00;
      endcase
   endfunction

   // Number of done pulses at edges 0..last_edge after reset release.
   function automatic int exp_dones(input int h, input int gp, input int last_edge);
      int first;
      first = gp + 16 * h + 1;
      exp_dones = (last_edge - first) / (2 + 16 * h + gp) + 1;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int H  = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
      localparam int GP = (g == 0) ? 2 : 1;

      logic       miso_l = 1'b0;
      logic [7:0] din_l;
      logic       rst_l;

      assign din_l = (g == 0) ? din0 : ((g == 1) ? din1 : din2);
      assign rst_l = (g == 0) ? rst0 : rst_sw;

      spi_master #(.SCK_HALF(H), .GAP(GP)) u_dut (
         .clk      (clk),
         .rst_n    (rst_l),
         .MISO     (miso_l ^ ((g == 0) ? noise : 1'b0)),
         .data_in  (din_l),
         .MOSI     (mosi_w[g]),
         .data_out (dout_w[g]),
         .sck      (sck_w[g]),
         .cs       (cs_w[g]),
         .done     (done_w[g])
      );

      int         cyc       = 0;
      int         csf_cyc   = 0;
      int         last_done = -1;
      int         n_done    = 0;
      int         npulse    = 0;
      int         last_np   = 0;
      int         pops      = 0;
      int         bitp      = 7;
      logic       armed     = 1'b0;
      logic       in_xfer   = 1'b0;
      logic       pcs       = 1'b1;
      logic       psck      = 1'b0;
      logic       pmosi     = 1'b0;
      logic       pdone     = 1'b0;
      logic       cs_fell, cs_rose, sck_rose, sck_fell;
      logic [7:0] sb        = 8'h00;
      logic [7:0] txacc     = 8'h00;
      logic [7:0] exp_tx    = 8'h00;
      logic [7:0] pdin      = 8'h00;
      logic [7:0] pdout     = 8'h00;
      logic [7:0] last_dout = 8'h00;
      logic [7:0] last_tx   = 8'h00;

      always @(negedge clk) begin
         cyc++;
         cs_fell  = pcs && !cs_w[g];
         cs_rose  = !pcs && cs_w[g];
         sck_rose = !psck && sck_w[g];
         sck_fell = psck && !sck_w[g];

         if (sck_rose || sck_fell)
            check_eq("sck_while_cs_high", int'(pcs), 0);
         if (mosi_w[g] != pmosi)
            check_eq("mosi_change_edge", int'(sck_fell || cs_fell || cs_rose), 1);

         if (cs_fell) begin
            in_xfer = 1'b1;
            csf_cyc = cyc;
            npulse  = 0;
            txacc   = 8'h00;
            exp_tx  = pdin;
         end

         if (sck_rose && in_xfer) begin
            if (npulse == 0)
               check_eq("first_sck_rise_delay", cyc - csf_cyc, H);
            txacc = {txacc[6:0], mosi_w[g]};
            npulse++;
         end

         // Slave shifts its next bit out on each sck fall.
         if (sck_fell && in_xfer && bitp > 0) begin
            bitp--;
            miso_l = sb[bitp];
         end

         if (done_w[g]) begin
            check_eq("done_inside_xfer", int'(in_xfer), 1);
            check_eq("cs_rise_with_done", int'(cs_rose), 1);
            check_eq("done_one_clk", int'(pdone), 0);
            check_eq("rx_byte", int'(dout_w[g]), int'(sb));
            check_eq("tx_byte", int'(txacc), int'(exp_tx));
            check_eq("sck_pulses", npulse, 8);
            check_eq("cs_low_width", cyc - csf_cyc, 1 + 16 * H);
            check_eq("dout_hold", int'(pdout), int'(last_dout));
            if (last_done >= 0)
               check_eq("done_period", cyc - last_done, 2 + 16 * H + GP);
            last_done = cyc;
            last_dout = dout_w[g];
            last_tx   = txacc;
            last_np   = npulse;
            n_done++;
         end

         if (cs_rose) begin
            in_xfer = 1'b0;
            armed   = 1'b0;
         end

         // With cs high the slave presets bit 7 of its next byte.
         if (cs_w[g] && !armed) begin
            sb     = (g == 0 && pops < 7) ? pat(pops) : 8'($urandom);
            pops++;
            bitp   = 7;
            miso_l = sb[7];
            armed  = 1'b1;
         end

         if (rst_l) begin
            last_done = -1;
            last_dout = 8'h00;
         end

         pcs   = cs_w[g];
         psck  = sck_w[g];
         pmosi = mosi_w[g];
         pdone = done_w[g];
         pdout = dout_w[g];
         pdin  = din_l;
      end
   end

   initial begin
      int ndone_win;
      ndone_win = 0;

      // Reset held for four clocks with inputs toggling.
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check_eq("rst_cs",   int'(cs_w[0]),   1);
         check_eq("rst_sck",  int'(sck_w[0]),  0);
         check_eq("rst_mosi", int'(mosi_w[0]), 0);
         check_eq("rst_done", int'(done_w[0]), 0);
         check_eq("rst_dout", int'(dout_w[0]), 0);
         din0  = 8'($urandom);
         noise = ~noise;
         if (i == 3) begin
            rst0   = 1'b0;
            rst_sw = 1'b0;
            noise  = 1'b0;
            din0   = 8'hAF;
         end
      end

      // k = index of the clk edge just taken, counted from reset release.
      for (int k = 0; k <= 700; k++) begin
         @(posedge clk); #1;
         if (k >= 197 && k <= 233 && done_w[0]) ndone_win++;
         case (k)
            1:   check_eq("cs_high_in_idle", int'(cs_w[0]), 1);
            2: begin
               check_eq("cs_fall_edge2", int'(cs_w[0]), 0);
               check_eq("mosi_bit7_load", int'(mosi_w[0]), 1);
            end
            4:   check_eq("sck_first_rise", int'(sck_w[0]), 1);
            34:  check_eq("done_not_early", int'(done_w[0]), 0);
            35: begin
               check_eq("done_edge35", int'(done_w[0]), 1);
               check_eq("loopback_rx", int'(dout_w[0]), 8'h5A);
            end
            36: begin
               check_eq("done_pulse_end", int'(done_w[0]), 0);
               check_eq("loopback_tx", int'(g_inst[0].last_tx), 8'hAF);
               check_eq("loopback_pulses", g_inst[0].last_np, 8);
            end
            50:  din0 = 8'h3C;
            71:  check_eq("pattern_ff", int'(dout_w[0]), 8'hFF);
            72:  check_eq("tx_unchanged_midxfer", int'(g_inst[0].last_tx), 8'hAF);
            107: check_eq("pattern_00", int'(dout_w[0]), 8'h00);
            108: check_eq("tx_new_value", int'(g_inst[0].last_tx), 8'h3C);
            109: din0 = 8'h96;
            143: check_eq("pattern_81", int'(dout_w[0]), 8'h81);
            144: check_eq("tx_load_cycle_value", int'(g_inst[0].last_tx), 8'h96);
            179: check_eq("pattern_11", int'(dout_w[0]), 8'h11);
            196: begin
               check_eq("sck_high_4th_rise", int'(sck_w[0]), 1);
               rst0 = 1'b1;
               din0 = 8'hA5;
            end
            197: begin
               check_eq("abort_cs",   int'(cs_w[0]),   1);
               check_eq("abort_sck",  int'(sck_w[0]),  0);
               check_eq("abort_mosi", int'(mosi_w[0]), 0);
               check_eq("abort_done", int'(done_w[0]), 0);
               check_eq("abort_dout", int'(dout_w[0]), 0);
            end
            198: rst0 = 1'b0;
            233: check_eq("no_done_after_abort", ndone_win, 0);
            234: begin
               check_eq("fresh_done", int'(done_w[0]), 1);
               check_eq("fresh_rx", int'(dout_w[0]), 8'h33);
            end
            235: begin
               check_eq("fresh_tx", int'(g_inst[0].last_tx), 8'hA5);
               check_eq("fresh_pulses", g_inst[0].last_np, 8);
            end
            default: ;
         endcase
         if ($urandom_range(3) == 0) din1 = 8'($urandom);
         if ($urandom_range(3) == 0) din2 = 8'($urandom);
      end

      check_eq("sweep_h1_transfers", g_inst[1].n_done, exp_dones(1, 1, 699));
      check_eq("sweep_h4_transfers", g_inst[2].n_done, exp_dones(4, 1, 699));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
